// File: rtl/dm_access_arbiter.sv
// Data-memory port arbiter: shares one DM port between the pipeline MEM stage
// (single-word accesses) and a DMA/loader port (incrementing bursts).
// One DM access per cycle; DM signals are driven from registers and read data
// is returned registered, two cycles after the grant.
module dm_access_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LEN_W-1:0]  d_len,
    output logic              d_gnt,
    output logic              d_beat,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              DM_read,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_addr,
    output logic [DATA_W-1:0] DM_in,
    input  logic [DATA_W-1:0] DM_out
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic [LEN_W-1:0]  rem;        // beats still owed after the current one
    logic [ADDR_W-1:0] ptr;        // address of the next burst beat
    logic              bwe;        // direction of the active burst
    logic              last_core;  // previous grant went to the core
    logic              p_core_rd;  // DM access in flight is a core read
    logic              p_dma_rd;   // DM access in flight is a DMA read
    logic              p_last;     // DM access in flight is the last burst beat

    logic              len_ok;
    logic              core_win;
    logic              dma_win;
    logic              last_beat;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // Per-cycle slot arbitration and selection of the granted access
    always_comb begin
        len_ok    = (d_len != '0) && (d_len <= LEN_W'(MAX_BURST));
        core_win  = 1'b0;
        dma_win   = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                if (c_req && !(d_req && len_ok && last_core))
                    core_win = 1'b1;
                else if (d_req && len_ok)
                    dma_win = 1'b1;
            end else begin
                if (c_req && !last_core)
                    core_win = 1'b1;
                else
                    dma_win = 1'b1;
            end
        end

        if (core_win) begin
            acc_we    = c_we;
            acc_addr  = c_addr;
            acc_wdata = c_wdata;
        end else if (state == IDLE) begin
            acc_we    = d_we;
            acc_addr  = d_addr;
            acc_wdata = d_wdata;
        end else begin
            acc_we    = bwe;
            acc_addr  = ptr;
            acc_wdata = d_wdata;
        end

        last_beat = dma_win && (((state == IDLE) && (d_len == LEN_W'(1))) ||
                                ((state == BURST) && (rem == LEN_W'(1))));

        c_gnt  = core_win;
        d_beat = dma_win;
        d_gnt  = dma_win && (state == IDLE);
    end

    // Burst FSM, DM drive registers and registered read return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rem       <= '0;
            ptr       <= '0;
            bwe       <= 1'b0;
            last_core <= 1'b0;
            p_core_rd <= 1'b0;
            p_dma_rd  <= 1'b0;
            p_last    <= 1'b0;
            DM_read   <= 1'b0;
            DM_write  <= 1'b0;
            DM_addr   <= '0;
            DM_in     <= '0;
            c_rdata   <= '0;
            c_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_rvalid  <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            DM_read  <= (core_win || dma_win) && !acc_we;
            DM_write <= (core_win || dma_win) && acc_we;
            if (core_win || dma_win)
                DM_addr <= acc_addr;
            if ((core_win || dma_win) && acc_we)
                DM_in <= acc_wdata;

            p_core_rd <= core_win && !acc_we;
            p_dma_rd  <= dma_win && !acc_we;
            p_last    <= last_beat;

            c_rvalid <= p_core_rd;
            if (p_core_rd)
                c_rdata <= DM_out;
            d_rvalid <= p_dma_rd;
            if (p_dma_rd)
                d_rdata <= DM_out;
            d_done <= p_last;

            if (core_win)
                last_core <= 1'b1;
            else if (dma_win)
                last_core <= 1'b0;

            if (dma_win) begin
                if (state == IDLE) begin
                    // First beat uses d_addr directly; only multi-beat bursts enter BURST
                    if (d_len != LEN_W'(1)) begin
                        state <= BURST;
                        rem   <= d_len - LEN_W'(1);
                        ptr   <= d_addr + ADDR_W'(1);
                        bwe   <= d_we;
                    end
                end else begin
                    rem <= rem - LEN_W'(1);
                    ptr <= ptr + ADDR_W'(1);
                    if (rem == LEN_W'(1))
                        state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Testbench for dm_access_arbiter: transaction-level model (burst expanded into
// a queue of beat addresses, reference memory) checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_dm_access_arbiter;

    localparam int MAX_BURST = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [15:0] c_addr = '0;
    logic [31:0] c_wdata = '0;
    logic        c_gnt, c_rvalid;
    logic [31:0] c_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [4:0]  d_len = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_beat, d_rvalid, d_done;
    logic [31:0] d_rdata;
    logic        DM_read, DM_write;
    logic [15:0] DM_addr;
    logic [31:0] DM_in, DM_out;

    logic [31:0] dm_mem [0:65535];

    dm_access_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len),
        .d_gnt(d_gnt), .d_beat(d_beat), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .DM_read(DM_read), .DM_write(DM_write), .DM_addr(DM_addr),
        .DM_in(DM_in), .DM_out(DM_out)
    );

    always #5 clk = ~clk;

    // DM instance stand-in: combinational read, write on posedge
    assign DM_out = dm_mem[DM_addr];
    always @(posedge clk) if (DM_write) dm_mem[DM_addr] <= DM_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed { logic [15:0] addr; logic we; logic last; } beat_t;
    beat_t       bq[$];
    beat_t       b;
    logic [31:0] ref_mem [0:65535];
    bit          last_core;
    bit          g_core, g_dma, g_new, legal, acc_we;
    logic [15:0] acc_addr;
    logic [31:0] acc_data;
    bit          e_rd, e_wr, e_crv, e_drv, e_done;
    logic [15:0] e_addr;
    logic [31:0] e_in, e_crd, e_drd;
    bit          a_core_rd, a_dma_rd, a_last;
    logic [31:0] a_val;

    // logs of actual DUT activity for the literal checks
    string       ord_str;
    logic [15:0] addr_log[$];
    logic [31:0] crd_log[$];
    logic [31:0] drd_log[$];
    int          done_cnt, done_rv_cnt;

    task automatic clear_logs();
        ord_str = "";
        addr_log.delete();
        crd_log.delete();
        drd_log.delete();
        done_cnt = 0;
        done_rv_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            bq.delete();
            last_core = 0;
            g_core = 0; g_dma = 0; g_new = 0;
            e_rd = 0; e_wr = 0; e_addr = '0; e_in = '0;
            e_crv = 0; e_drv = 0; e_done = 0; e_crd = '0; e_drd = '0;
            a_core_rd = 0; a_dma_rd = 0; a_last = 0; a_val = '0;
        end else begin
            legal = d_req && (d_len >= 5'd1) && (int'(d_len) <= MAX_BURST);
            g_core = 0; g_dma = 0; g_new = 0;
            if (bq.size() == 0) begin
                if (c_req && !(legal && last_core)) g_core = 1;
                else if (legal) begin g_dma = 1; g_new = 1; end
            end else if (c_req && !last_core) g_core = 1;
            else g_dma = 1;
        end

        check("c_gnt", c_gnt, g_core);
        check("d_gnt", d_gnt, g_new);
        check("d_beat", d_beat, g_dma);
        check("DM_read", DM_read, e_rd);
        check("DM_write", DM_write, e_wr);
        check("DM_addr", DM_addr, e_addr);
        check("DM_in", DM_in, e_in);
        check("c_rvalid", c_rvalid, e_crv);
        check("c_rdata", c_rdata, e_crd);
        check("d_rvalid", d_rvalid, e_drv);
        check("d_rdata", d_rdata, e_drd);
        check("d_done", d_done, e_done);

        if (c_gnt) ord_str = {ord_str, "C"};
        if (d_beat) ord_str = {ord_str, "D"};
        if (DM_read || DM_write) addr_log.push_back(DM_addr);
        if (c_rvalid) crd_log.push_back(c_rdata);
        if (d_rvalid) drd_log.push_back(d_rdata);
        if (d_done) begin
            done_cnt++;
            if (d_rvalid) done_rv_cnt++;
        end

        if (rst) begin
            e_crv = a_core_rd; if (a_core_rd) e_crd = a_val;
            e_drv = a_dma_rd;  if (a_dma_rd) e_drd = a_val;
            e_done = a_last;
            a_core_rd = 0; a_dma_rd = 0; a_last = 0;
            e_rd = 0; e_wr = 0;
            if (g_new)
                for (int k = 0; k < int'(d_len); k++)
                    bq.push_back('{addr: d_addr + 16'(k), we: d_we, last: (k == int'(d_len) - 1)});
            acc_we = 0; acc_addr = '0; acc_data = '0;
            if (g_core) begin
                acc_addr = c_addr; acc_we = c_we; acc_data = c_wdata;
                a_core_rd = !c_we; last_core = 1;
            end
            if (g_dma) begin
                b = bq.pop_front();
                acc_addr = b.addr; acc_we = b.we; acc_data = d_wdata;
                a_dma_rd = !b.we; a_last = b.last; last_core = 0;
            end
            if (g_core || g_dma) begin
                e_addr = acc_addr;
                e_rd = !acc_we;
                e_wr = acc_we;
                if (acc_we) begin
                    e_in = acc_data;
                    ref_mem[acc_addr] = acc_data;
                end else begin
                    a_val = ref_mem[acc_addr];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] cl_addr [8];
    logic [31:0] cl_data [8];
    logic        cl_we   [8];
    int          c_n, c_idx;
    logic [31:0] wtbl [16];
    int          w_idx;

    task automatic load_core(input int i);
        c_we = cl_we[i]; c_addr = cl_addr[i]; c_wdata = cl_data[i];
    endtask

    task automatic start_core(input int n);
        c_n = n; c_idx = 0; load_core(0); c_req = 1;
    endtask

    task automatic start_dma(input logic we, input logic [15:0] addr, input logic [4:0] len);
        d_we = we; d_addr = addr; d_len = len; w_idx = 0; d_wdata = wtbl[0]; d_req = 1;
    endtask

    // one clock: observe grants mid-cycle, then advance requesters after the edge
    task automatic cyc();
        logic gc, gd, bd;
        @(negedge clk);
        gc = c_gnt; gd = d_gnt; bd = d_beat;
        @(posedge clk);
        #1;
        if (gc) begin
            c_idx++;
            if (c_idx < c_n) load_core(c_idx); else c_req = 0;
        end
        if (gd) d_req = 0;
        if (bd) begin
            w_idx++;
            if (w_idx < 16) d_wdata = wtbl[w_idx];
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((c_req || d_req || bq.size() != 0) && k < 200) begin
            cyc();
            k++;
        end
        if (k >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: requests still pending after %0d cycles", k);
        end
        repeat (3) cyc();
    endtask

    task automatic check_q16(input string name, input logic [15:0] exp[$]);
        check({name, "_count"}, addr_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < addr_log.size(); i++)
            check(name, addr_log[i], exp[i]);
    endtask

    task automatic check_q32(input string name, input logic [31:0] act[$], input logic [31:0] exp[$]);
        check({name, "_count"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            check(name, act[i], exp[i]);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 65536; i++) begin dm_mem[i] = '0; ref_mem[i] = '0; end
        for (int i = 0; i < 16; i++) wtbl[i] = '0;
        clear_logs();
        #1 rst = 0;

        // 1: reset with both requests up, then core wins the first tie
        c_req = 1; c_we = 0; c_addr = 16'h0005;
        start_dma(1'b0, 16'h0007, 5'd1);
        repeat (4) cyc();
        check_str("reset_no_grants", ord_str, "");
        clear_logs();
        rst = 1;
        cl_we[0] = 0; cl_addr[0] = 16'h0005; cl_data[0] = '0;
        start_core(1);
        drain();
        check_str("reset_release_order", ord_str, "CD");

        // 2: core write then read back
        clear_logs();
        cl_we[0] = 1; cl_addr[0] = 16'h0010; cl_data[0] = 32'h12345678;
        cl_we[1] = 0; cl_addr[1] = 16'h0010; cl_data[1] = '0;
        start_core(2);
        drain();
        check_q16("core_addrs", '{16'h0010, 16'h0010});
        check_q32("core_rdata", crd_log, '{32'h12345678});

        // 3: DMA write burst of 4 then read it back
        clear_logs();
        for (int i = 0; i < 4; i++) wtbl[i] = 32'(i + 1);
        start_dma(1'b1, 16'h0020, 5'd4);
        drain();
        check("wr_burst_done", done_cnt, 1);
        clear_logs();
        start_dma(1'b0, 16'h0020, 5'd4);
        drain();
        check_q32("rd_burst_data", drd_log, '{32'd1, 32'd2, 32'd3, 32'd4});
        check("rd_burst_done", done_cnt, 1);
        check("rd_done_with_rvalid", done_rv_cnt, 1);

        // 4: contention, core held for 3 reads during a 4-beat burst
        clear_logs();
        start_dma(1'b0, 16'h0020, 5'd4);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cl_we[i] = 0; cl_addr[i] = 16'h0010 + 16'(i); cl_data[i] = '0;
        end
        start_core(3);
        drain();
        check_str("contention_order", ord_str, "DCDCDCD");
        check_q16("contention_addrs", '{16'h0020, 16'h0010, 16'h0021, 16'h0011,
                                        16'h0022, 16'h0012, 16'h0023});
        check_q32("contention_crdata", crd_log, '{32'h12345678, 32'h0, 32'h0});
        check_q32("contention_drdata", drd_log, '{32'd1, 32'd2, 32'd3, 32'd4});

        // 5: address wrap
        clear_logs();
        for (int i = 0; i < 4; i++) wtbl[i] = 32'(i + 5);
        start_dma(1'b1, 16'hFFFE, 5'd4);
        drain();
        check_q16("wrap_addrs", '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});
        clear_logs();
        start_dma(1'b0, 16'hFFFE, 5'd4);
        drain();
        check_q32("wrap_rdata", drd_log, '{32'd5, 32'd6, 32'd7, 32'd8});

        // illegal lengths: never granted, no DM traffic
        clear_logs();
        start_dma(1'b0, 16'h0040, 5'd0);
        repeat (6) cyc();
        d_len = 5'd17;
        repeat (6) cyc();
        d_req = 0;
        repeat (3) cyc();
        check("illegal_dm_accesses", addr_log.size(), 0);
        check_str("illegal_grants", ord_str, "");

        // 6: reset in the middle of a len=8 burst, then a fresh len=1 burst
        clear_logs();
        start_dma(1'b0, 16'h0100, 5'd8);
        k = 0;
        while (ord_str.len() < 2 && k < 20) begin cyc(); k++; end
        check("beats_before_reset", ord_str.len(), 2);
        rst = 0;
        repeat (3) cyc();
        rst = 1;
        repeat (12) cyc();
        check("abandoned_no_done", done_cnt, 0);
        clear_logs();
        start_dma(1'b0, 16'h0020, 5'd1);
        drain();
        check("post_reset_done", done_cnt, 1);
        check_q32("post_reset_rdata", drd_log, '{32'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
